// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Words written through i_Tx_DV/i_Tx_Byte are queued in a FIFO and sent
// as start / data (LSB first) / optional parity / stop frames. Frames are
// sent back-to-back while the FIFO holds words.
// Optional feature: define UART_TX_PARITY_EN to add one parity bit after
// the data bits (even parity, or odd when PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 2,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [15:0]      CPB_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration time.
    generate
        if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535) ||
            (DATA_BITS < 5) || (DATA_BITS > 9) ||
            (STOP_BITS < 1) || (STOP_BITS > 2) ||
            (FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) ||
            ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
            (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_param
            $error("uart_tx_fifo: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_INIT = 1'(PARITY_ODD);

    // Parity of a data word, before the odd/even selection.
    function automatic logic word_parity(input logic [DATA_BITS-1:0] w);
        return ^w;
    endfunction

    logic parity_r;
`endif

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_n;
    logic                 wr_s;
    logic                 pop_s;
    logic [DATA_BITS-1:0] pop_data_s;

    // Transmitter state
    state_t               state_r;
    state_t               state_n;
    logic [15:0]          clk_cnt_r;
    logic [15:0]          clk_cnt_n;
    logic [3:0]           bit_idx_r;
    logic [3:0]           bit_idx_n;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_n;
    logic                 bit_end_s;

    // Registered outputs
    logic                 serial_r;
    logic                 serial_n;
    logic                 active_r;
    logic                 active_n;
    logic                 done_r;
    logic                 done_n;
    logic                 overflow_r;
    logic                 ready_r;

    assign wr_s       = i_Tx_DV && (count_r != DEPTH_C);
    assign pop_data_s = mem_r[rd_ptr_r];
    assign bit_end_s  = (clk_cnt_r == CPB_LAST);

    // FIFO data array; written only on accepted writes, never reset.
    always_ff @(posedge i_Clock) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= i_Tx_Byte;
        end
    end

    // Next word count: a simultaneous write and pop cancel out.
    always_comb begin
        count_n = count_r;
        case ({wr_s, pop_s})
            2'b10:   count_n = count_r + CNT_ONE;
            2'b01:   count_n = count_r - CNT_ONE;
            default: count_n = count_r;
        endcase
    end

    // Next-state, bit timing and next line value for the frame sequencer.
    always_comb begin
        state_n   = state_r;
        clk_cnt_n = clk_cnt_r;
        bit_idx_n = bit_idx_r;
        shift_n   = shift_r;
        serial_n  = serial_r;
        pop_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    pop_s     = 1'b1;
                    state_n   = S_START;
                    clk_cnt_n = 16'd0;
                    shift_n   = pop_data_s;
                    serial_n  = 1'b0;
                end else begin
                    serial_n  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_n   = S_DATA;
                    clk_cnt_n = 16'd0;
                    bit_idx_n = 4'd0;
                    serial_n  = shift_r[0];
                    shift_n   = {1'b0, shift_r[DATA_BITS-1:1]};
                end else begin
                    clk_cnt_n = clk_cnt_r + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    clk_cnt_n = 16'd0;
                    if (bit_idx_r == DATA_LAST) begin
                        bit_idx_n = 4'd0;
`ifdef UART_TX_PARITY_EN
                        state_n   = S_PARITY;
                        serial_n  = parity_r;
`else
                        state_n   = S_STOP;
                        serial_n  = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx_r + 4'd1;
                        serial_n  = shift_r[0];
                        shift_n   = {1'b0, shift_r[DATA_BITS-1:1]};
                    end
                end else begin
                    clk_cnt_n = clk_cnt_r + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    state_n   = S_STOP;
                    clk_cnt_n = 16'd0;
                    bit_idx_n = 4'd0;
                    serial_n  = 1'b1;
                end else begin
                    clk_cnt_n = clk_cnt_r + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    clk_cnt_n = 16'd0;
                    if (bit_idx_r == STOP_LAST) begin
                        bit_idx_n = 4'd0;
                        // Chain straight into the next frame when words wait.
                        if (count_r != CNT_ZERO) begin
                            pop_s    = 1'b1;
                            state_n  = S_START;
                            shift_n  = pop_data_s;
                            serial_n = 1'b0;
                        end else begin
                            state_n  = S_IDLE;
                            serial_n = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx_r + 4'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt_r + 16'd1;
                end
            end
            default: begin
                state_n   = S_IDLE;
                clk_cnt_n = 16'd0;
                bit_idx_n = 4'd0;
                serial_n  = 1'b1;
            end
        endcase
        active_n = (state_n != S_IDLE);
        // Done is registered, so raise it on entry to the last stop cycle.
        done_n   = (state_n == S_STOP) && (clk_cnt_n == CPB_LAST) &&
                   (bit_idx_n == STOP_LAST);
    end

    // State, pointer, counter and output registers; reset clears everything.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r    <= S_IDLE;
            clk_cnt_r  <= 16'd0;
            bit_idx_r  <= 4'd0;
            shift_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            serial_r   <= 1'b1;
            active_r   <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            ready_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_n;
            clk_cnt_r  <= clk_cnt_n;
            bit_idx_r  <= bit_idx_n;
            shift_r    <= shift_n;
            wr_ptr_r   <= wr_s  ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r   <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            count_r    <= count_n;
            serial_r   <= serial_n;
            active_r   <= active_n;
            done_r     <= done_n;
            overflow_r <= i_Tx_DV && (count_r == DEPTH_C);
            ready_r    <= (count_n != DEPTH_C);
`ifdef UART_TX_PARITY_EN
            parity_r   <= pop_s ? (word_parity(pop_data_s) ^ PARITY_INIT) : parity_r;
`endif
        end
    end

    assign o_Tx_Ready   = ready_r;
    assign o_Tx_Serial  = serial_r;
    assign o_Tx_Active  = active_r;
    assign o_Tx_Done    = done_r;
    assign o_Overflow   = overflow_r;
    assign o_Fifo_Count = count_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: two instances (default configuration and a
// 7-bit / 2-stop / 3-clock / depth-4 configuration). Stimulus pushes the
// words it expects on the line into per-instance queues; a monitor per
// instance decodes each frame cycle by cycle and checks it against them.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL0 = 2 * (1 + 8 + PAR + 1);
    localparam int FL1 = 3 * (1 + 7 + PAR + 2);

    logic       clk = 1'b0;
    logic       rst0, rst1, dv0, dv1;
    logic [7:0] byte0;
    logic [6:0] byte1;
    logic       ready0, ser0, act0, done0, ovf0;
    logic       ready1, ser1, act1, done1, ovf1;
    logic [4:0] cnt0;
    logic [2:0] cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    always #5 clk = ~clk;

    uart_tx_fifo dut0 (
        .i_Clock(clk), .i_Rst_L(rst0), .i_Tx_DV(dv0), .i_Tx_Byte(byte0),
        .o_Tx_Ready(ready0), .o_Tx_Serial(ser0), .o_Tx_Active(act0),
        .o_Tx_Done(done0), .o_Overflow(ovf0), .o_Fifo_Count(cnt0)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(3), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut1 (
        .i_Clock(clk), .i_Rst_L(rst1), .i_Tx_DV(dv1), .i_Tx_Byte(byte1),
        .o_Tx_Ready(ready1), .o_Tx_Serial(ser1), .o_Tx_Active(act1),
        .o_Tx_Done(done1), .o_Overflow(ovf1), .o_Fifo_Count(cnt1)
    );

    function automatic logic get_ser(input int d);  return (d == 0) ? ser0  : ser1;  endfunction
    function automatic logic get_act(input int d);  return (d == 0) ? act0  : act1;  endfunction
    function automatic logic get_done(input int d); return (d == 0) ? done0 : done1; endfunction
    function automatic logic get_rst(input int d);  return (d == 0) ? rst0  : rst1;  endfunction
    function automatic int   get_cnt(input int d);  return (d == 0) ? int'(cnt0) : int'(cnt1); endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [8:0] w);
        if (d == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    // Expected line level for sample i of a frame carrying word w.
    function automatic logic exp_line(input logic [8:0] w, input int i,
                                      input int cpb, input int db);
        int b;
        b = i / cpb;
        if (b == 0) return 1'b0;
        if (b <= db) return w[b-1];
        if ((PAR == 1) && (b == db + 1)) return ^w;
        return 1'b1;
    endfunction

    // Drive one write (called at a negedge); returns at the next negedge.
    task automatic wr(input int d, input logic [8:0] w);
        if (d == 0) begin dv0 = 1'b1; byte0 = w[7:0]; end
        else        begin dv1 = 1'b1; byte1 = w[6:0]; end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Waits for o_Tx_Active, then measures how long it stays high.
    task automatic measure(input int d, output int len, output int peak, output int dones);
        int t;
        len = 0; peak = 0; dones = 0; t = 0;
        while (!get_act(d) && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            check($sformatf("active_timeout_d%0d", d), 0, 1);
        end else begin
            while (get_act(d) && t < 3000) begin
                len++;
                if (get_cnt(d) > peak) peak = get_cnt(d);
                if (get_done(d)) dones++;
                @(negedge clk);
                t++;
            end
        end
    endtask

    // Frame monitor: on a start bit, pop the expected word and check every cycle.
    task automatic monitor(input int d, input int cpb, input int db, input int sb);
        int fl, bad_line, bad_done, bad_act;
        bit aborted;
        logic [8:0] w;
        fl = cpb * (1 + db + PAR + sb);
        forever begin
            @(negedge clk);
            if (get_rst(d) && (get_ser(d) == 1'b0)) begin
                if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("unexpected_frame_d%0d", d), 1, 0);
                    repeat (fl - 1) @(negedge clk);
                end else begin
                    w = (d == 0) ? q0.pop_front() : q1.pop_front();
                    bad_line = 0; bad_done = 0; bad_act = 0; aborted = 1'b0;
                    for (int i = 0; i < fl; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!get_rst(d)) begin aborted = 1'b1; break; end
                        if (get_ser(d) !== exp_line(w, i, cpb, db)) bad_line++;
                        if (get_done(d) !== (i == fl - 1)) bad_done++;
                        if (get_act(d) !== 1'b1) bad_act++;
                    end
                    if (!aborted) begin
                        check($sformatf("frame_line_d%0d_w%0h", d, w), bad_line, 0);
                        check($sformatf("frame_done_d%0d_w%0h", d, w), bad_done, 0);
                        check($sformatf("frame_active_d%0d_w%0h", d, w), bad_act, 0);
                    end
                end
            end
        end
    endtask

    initial monitor(0, 2, 8, 1);
    initial monitor(1, 3, 7, 2);

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, peak, dones, bad;
        logic [8:0] w1 [6];
        logic rdy [6];
        logic ov  [6];
        logic ov_after;
        int cnt_after;

        rst0 = 1'b0; rst1 = 1'b0; dv0 = 1'b0; dv1 = 1'b0;
        byte0 = 8'h00; byte1 = 7'h00;
        repeat (3) @(negedge clk);
        #1;
        // Reset values {serial, active, done, overflow, ready, count}
        check("reset_d0", {ser0, act0, done0, ovf0, ready0, 3'b000, cnt0}, 13'b1_0_0_0_1_000_00000);
        check("reset_d1", {ser1, act1, done1, ovf1, ready1, cnt1}, 8'b1_0_0_0_1_000);
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1;

        // Single word right after reset release: no bypass, 20-cycle frame.
        push(0, 9'h001);
        fork
            measure(0, len, peak, dones);
            begin
                wr(0, 9'h001);
                dv0 = 1'b0;
                check("first_write_count", cnt0, 1);
                check("no_bypass_line", ser0, 1);
            end
        join
        check("single_len", len, FL0);
        check("single_dones", dones, 1);

        // Six words back-to-back.
        for (int i = 0; i < 5; i++) push(0, 9'h000);
        push(0, 9'h010);
        fork
            measure(0, len, peak, dones);
            begin
                for (int i = 0; i < 5; i++) wr(0, 9'h000);
                wr(0, 9'h010);
                dv0 = 1'b0;
            end
        join
        check("b2b_len", len, 6 * FL0);
        check("b2b_peak_count", peak, 5);
        check("b2b_dones", dones, 6);

        // Depth-4 instance: six writes, fifth fills it, sixth overflows.
        w1[0] = 9'h055; w1[1] = 9'h02A; w1[2] = 9'h00F;
        w1[3] = 9'h070; w1[4] = 9'h001; w1[5] = 9'h07F;
        for (int i = 0; i < 5; i++) push(1, w1[i]);
        fork
            measure(1, len, peak, dones);
            begin
                for (int i = 0; i < 6; i++) begin
                    wr(1, w1[i]);
                    rdy[i] = ready1;
                    ov[i]  = ovf1;
                end
                cnt_after = int'(cnt1);
                dv1 = 1'b0;
                @(negedge clk);
                ov_after = ovf1;
            end
        join
        check("full_ready_after_4", rdy[3], 1);
        check("full_ready_after_5", rdy[4], 0);
        check("full_ovf_after_5", ov[4], 0);
        check("full_ovf_after_6", ov[5], 1);
        check("full_ovf_pulse_end", ov_after, 0);
        check("full_count_after_6", cnt_after, 4);
        check("full_len", len, 5 * FL1);
        check("full_dones", dones, 5);

        // Reset during data bit 3 with two words buffered.
        push(0, 9'h000); push(0, 9'h0FF); push(0, 9'h081);
        wr(0, 9'h000); wr(0, 9'h0FF); wr(0, 9'h081);
        dv0 = 1'b0;
        check("pre_reset_count", cnt0, 2);
        repeat (7) @(negedge clk);
        check("pre_reset_line", ser0, 0);
        check("pre_reset_active", act0, 1);
        #2;
        rst0 = 1'b0;
        q0.delete();
        #1;
        check("async_reset_line", ser0, 1);
        check("async_reset_state", {act0, ready0, 3'b000, cnt0}, 10'b0_1_000_00000);
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (act0 || !ser0) bad++;
        end
        check("quiet_after_reset", bad, 0);
        push(0, 9'h05A);
        fork
            measure(0, len, peak, dones);
            begin wr(0, 9'h05A); dv0 = 1'b0; end
        join
        check("post_reset_len", len, FL0);

        repeat (4) @(negedge clk);
        check("drained_q0", q0.size(), 0);
        check("drained_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 2: clock cycles per serial bit, legal range 2 to 65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5 to 9.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: transmit buffer entries, power of two, 2 to 256.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only when UART_TX_PARITY_EN is defined.
REQ-006 SHALL have port: i_Clock  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port: i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port: i_Tx_DV  input  1  write strobe; i_Tx_Byte is valid this cycle.
REQ-009 SHALL have port: i_Tx_Byte  input  DATA_BITS  word to transmit.
REQ-010 SHALL have port: o_Tx_Ready  output  1  high when the FIFO is not full.
REQ-011 SHALL have port: o_Tx_Serial  output  1  serial line; idle high.
REQ-012 SHALL have port: o_Tx_Active  output  1  high while a frame is on the line.
REQ-013 SHALL have port: o_Tx_Done  output  1  one-cycle pulse in the last cycle of each frame's final stop bit.
REQ-014 SHALL have port: o_Overflow  output  1  one-cycle pulse when a write is dropped.
REQ-015 SHALL have port: o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  number of words buffered, not counting the frame in flight.

Function
REQ-016 SHALL accept a write on any rising edge where i_Tx_DV=1 and count<FIFO_DEPTH; o_Tx_Ready SHALL equal (count<FIFO_DEPTH), registered.
REQ-017 SHALL drop a write when i_Tx_DV=1 and count=FIFO_DEPTH, leave the FIFO unchanged, and pulse o_Overflow on the next cycle.
REQ-018 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE SHALL go to START on the edge where count>0 at the start of the cycle: pop one word into the shift register and drive o_Tx_Serial=0. There is no same-cycle bypass from write to pop.
REQ-020 A write accepted at edge k into an empty, idle block SHALL produce a start bit from edge k+1.
REQ-021 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that reloads at every bit boundary.
REQ-022 DATA SHALL send DATA_BITS bits LSB first, then go to PARITY (macro defined) or STOP.
REQ-023 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles and pulse o_Tx_Done in the final cycle.
REQ-024 At the end of STOP with count>0, the FSM SHALL pop and begin the next start bit on the next edge with zero idle cycles; otherwise it SHALL return to IDLE.
REQ-025 A simultaneous write and pop SHALL leave count unchanged, and both operations SHALL take effect.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 o_Tx_Active SHALL be 1 from the first start-bit cycle through the last stop-bit cycle, and stays 1 across back-to-back frames.

Reset
REQ-028 Assertion of i_Rst_L=0 SHALL immediately, without waiting for a clock edge: force o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Fifo_Count=0, o_Tx_Ready=1, FSM=IDLE, and clear the pointers and bit counters.
REQ-029 Reset mid-frame SHALL abort the frame and discard all buffered words.
REQ-030 The first write SHALL be accepted on the first rising edge after deassertion.

Configuration
REQ-031 Macro UART_TX_PARITY_EN, when defined, SHALL insert one parity bit of CLKS_PER_BIT cycles after the data bits: the XOR of the data bits, XORed with PARITY_ODD.
REQ-032 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-033 Defaults, no macro, write 0x01 into an idle block:
- line low for cycles 1-2 after acceptance;
- then bits 1,0,0,0,0,0,0,0 at 2 cycles each;
- then high for 2 cycles with o_Tx_Done in the last of them;
- 20 cycles total.
REQ-034 Write 0x00 ×5 then 0x10 on consecutive cycles: the six frames SHALL appear back-to-back (120 cycles), o_Tx_Active SHALL stay high throughout, and o_Fifo_Count SHALL peak at 5.
REQ-035 With FIFO_DEPTH=4, write 6 words in consecutive cycles while idle:
- words 1-5 accepted (1 popped, 4 buffered);
- o_Tx_Ready low after the 5th write;
- the 6th write dropped with an o_Overflow pulse;
- exactly 5 frames sent.
REQ-036 Macro defined, PARITY_ODD=0, write 0x07: the parity bit SHALL be 1 and the frame SHALL be 11 bits (22 cycles); with PARITY_ODD=1 the parity bit SHALL be 0.
REQ-037 Assert i_Rst_L=0 during data bit 3 of a frame with 2 words buffered: o_Tx_Serial SHALL go high without a clock edge, count SHALL be 0, and no frame SHALL follow release until a new write.
REQ-038 STOP_BITS=2, DATA_BITS=7, CLKS_PER_BIT=3, write 0x55: the frame SHALL be 30 cycles with the line high for the final 6 cycles.
